// File: rtl/ramp_sequencer.sv
// ramp_sequencer: triangle-wave generator rising to a peak and falling to zero, for a set number of cycles or continuously
// Ports: clock, reset (sync, active-low); start/abort control; cfg_peak/cfg_step/cfg_cycles/cfg_div latched on an accepted start;
//        data_out ramp sample, dir (rising), busy (UP/DOWN), done (one-cycle completion pulse), cycles_done (completed cycles)
module ramp_sequencer #(
  parameter int DATA_W = 7,
  parameter int CYC_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_peak,
  input  logic [3:0]        cfg_step,
  input  logic [CYC_W-1:0]  cfg_cycles,
  input  logic [7:0]        cfg_div,
  output logic [DATA_W-1:0] data_out,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cycles_done
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] peak_q, data_n;
  logic [3:0] step_q;
  logic [CYC_W-1:0] cycles_q, cyc_n;
  logic [7:0] div_q, presc, presc_n;
  logic load, tick;
  logic [DATA_W:0] sum, step_w;
  assign dir = state == UP;
  assign busy = state == UP || state == DOWN;
  assign done = state == DONE;
  always_comb begin
    tick = busy && presc == div_q;
    step_w = (DATA_W+1)'(step_q);
    sum = {1'b0, data_out} + step_w;
    load = state == IDLE && start && !abort && cfg_peak != '0;
    state_n = state;
    data_n = data_out;
    cyc_n = cycles_done;
    presc_n = tick ? '0 : presc + 8'd1;
    case (state)
      IDLE: begin
        presc_n = '0;
        if (load) begin
          state_n = UP;
          data_n = '0;
          cyc_n = '0;
        end
      end
      UP: begin
        if (abort) begin
          state_n = IDLE;
          data_n = '0;
          presc_n = '0;
        end else if (tick) begin
          state_n = sum >= {1'b0, peak_q} ? DOWN : UP;
          data_n = sum >= {1'b0, peak_q} ? peak_q : sum[DATA_W-1:0];
        end
      end
      DOWN: begin
        if (abort) begin
          state_n = IDLE;
          data_n = '0;
          presc_n = '0;
        end else if (tick) begin
          if ({1'b0, data_out} <= step_w) begin
            data_n = '0;
            cyc_n = cycles_done + CYC_W'(1);
            state_n = (cycles_q != '0 && cyc_n == cycles_q) ? DONE : UP;
          end else begin
            data_n = DATA_W'({1'b0, data_out} - step_w);
          end
        end
      end
      default: begin
        state_n = IDLE;
        data_n = '0;
        presc_n = '0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      data_out <= '0;
      cycles_done <= '0;
      presc <= '0;
      peak_q <= '0;
      step_q <= '0;
      cycles_q <= '0;
      div_q <= '0;
    end else begin
      state <= state_n;
      data_out <= data_n;
      cycles_done <= cyc_n;
      presc <= presc_n;
      if (load) begin
        peak_q <= cfg_peak;
        step_q <= cfg_step == 4'd0 ? 4'd1 : cfg_step;
        cycles_q <= cfg_cycles;
        div_q <= cfg_div;
      end
    end
  end
endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: vector table, reference-model runs and hand sequences for ramp_sequencer
module tb_ramp_sequencer;
  logic clock = 0, reset = 0, start = 0, abort = 0;
  logic [6:0] cfg_peak = 0;
  logic [3:0] cfg_step = 0;
  logic [7:0] cfg_cycles = 0, cfg_div = 0;
  logic [6:0] data_out;
  logic dir, busy, done;
  logic [7:0] cycles_done;
  int checks = 0, failures = 0;
  typedef logic [17:0] obs_t;
  typedef struct {
    bit rst_n, st, ab;
    int peak, stp, cyc, div;
    int d;
    bit dr, bz, dn;
    int cd;
  } vec_t;
  obs_t act;
  obs_t exp_q[$];
  vec_t tbl[$];
  ramp_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_peak(cfg_peak), .cfg_step(cfg_step), .cfg_cycles(cfg_cycles), .cfg_div(cfg_div),
    .data_out(data_out), .dir(dir), .busy(busy), .done(done), .cycles_done(cycles_done)
  );
  assign act = {data_out, dir, busy, done, cycles_done};
  always #5 clock = ~clock;
  function automatic obs_t mk(input int d, input bit dr, input bit bz, input bit dn, input int cd);
    return {7'(d), dr, bz, dn, 8'(cd)};
  endfunction
  task automatic chk(input string name, input obs_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got d=%0d dir=%0b busy=%0b done=%0b cd=%0d, want d=%0d dir=%0b busy=%0b done=%0b cd=%0d",
               name, act[17:11], act[10], act[9], act[8], act[7:0], e[17:11], e[10], e[9], e[8], e[7:0]);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic build(input int peak, input int stp, input int cyc, input int div);
    int v = 0, n = 0, s;
    bit up = 1;
    exp_q.delete();
    s = stp == 0 ? 1 : stp;
    repeat (div + 1) exp_q.push_back(mk(0, 1, 1, 0, 0));
    forever begin
      if (up) begin
        v += s;
        if (v >= peak) begin v = peak; up = 0; end
      end else begin
        v -= s;
        if (v <= 0) begin v = 0; n++; up = 1; end
      end
      if (v == 0 && n == cyc) begin
        exp_q.push_back(mk(0, 0, 0, 1, n));
        break;
      end
      repeat (div + 1) exp_q.push_back(mk(v, up, 1, 0, n));
    end
  endtask
  task automatic run(input string tag, input int peak, input int stp, input int cyc, input int div);
    build(peak, stp, cyc, div);
    cfg_peak = 7'(peak); cfg_step = 4'(stp); cfg_cycles = 8'(cyc); cfg_div = 8'(div);
    start = 1;
    step();
    foreach (exp_q[i]) begin
      chk($sformatf("%s[%0d]", tag, i), exp_q[i]);
      if (i < exp_q.size() - 1) begin
        start = 1'($urandom_range(0, 1));
        cfg_peak = 7'($urandom); cfg_step = 4'($urandom); cfg_cycles = 8'($urandom); cfg_div = 8'($urandom);
      end else start = 0;
      step();
    end
    chk({tag, "_idle"}, mk(0, 0, 0, 0, cyc));
  endtask
  initial begin
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 5, 3, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 3, 2, 1, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 9, 1, 0, 2, 2, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 4, 0, 0, 1, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 2, 1, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 1, 1, 7, 3, 1, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      reset = tbl[i].rst_n; start = tbl[i].st; abort = tbl[i].ab;
      cfg_peak = 7'(tbl[i].peak); cfg_step = 4'(tbl[i].stp); cfg_cycles = 8'(tbl[i].cyc); cfg_div = 8'(tbl[i].div);
      step();
      chk($sformatf("vec%0d", i), mk(tbl[i].d, tbl[i].dr, tbl[i].bz, tbl[i].dn, tbl[i].cd));
    end
    reset = 1; start = 0; abort = 0;
    step();
    run("peak100", 100, 1, 1, 0);
    run("peak10", 10, 4, 2, 0);
    run("div3", 2, 1, 1, 3);
    for (int r = 0; r < 6; r++)
      run($sformatf("rnd%0d", r), $urandom_range(1, 40), $urandom_range(0, 15), $urandom_range(1, 3), $urandom_range(0, 3));
    begin
      int k = 0;
      cfg_peak = 100; cfg_step = 1; cfg_cycles = 1; cfg_div = 0;
      start = 1;
      step();
      start = 0;
      while (data_out != 50 && k < 200) begin step(); k++; end
      chk("reach50", mk(50, 1, 1, 0, 0));
      abort = 1; start = 1;
      step();
      abort = 0; start = 0;
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("abort_idle%0d", j), mk(0, 0, 0, 0, 0));
        step();
      end
    end
    run("after_abort", 6, 2, 1, 1);
    cfg_peak = 1; cfg_step = 1; cfg_cycles = 0; cfg_div = 0;
    start = 1;
    step();
    start = 0;
    repeat (600) step();
    chk("wrap300", mk(0, 1, 1, 0, 44));
    step();
    chk("mid_down", mk(1, 0, 1, 0, 44));
    reset = 0; start = 1; abort = 1;
    step();
    chk("reset_mid", mk(0, 0, 0, 0, 0));
    reset = 1; start = 0; abort = 0;
    step();
    chk("post_reset", mk(0, 0, 0, 0, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
